// File: rtl/fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : fifo_wr_arbiter
//  Purpose  : Arbitrates N_REQ asynchronous button-style requesters onto the
//             write port of one shared FIFO. Each requester level is
//             synchronized and edge-detected into a pending bit. A
//             round-robin FSM (IDLE -> LOAD -> PULSE -> SETTLE) then issues
//             one slow, well-separated write per pending request. Lost
//             requests are counted in a saturating counter.
//  Ports    : clk        - clock, rising edge
//             rst        - asynchronous active-high reset
//             req        - per-requester asynchronous request level
//             din        - packed requester data, slice i = din[i*DW +: DW]
//             fifo_full  - full flag from the shared FIFO
//             fifo_wr    - registered write strobe
//             fifo_din   - registered write data, stable LOAD..end of SETTLE
//             grant      - registered one-hot owner, zero when idle
//             ack        - registered one-cycle pulse when a write is issued
//             drop_cnt   - saturating count of requests lost to overlap
//  Revision : 1.0 - initial release
// ============================================================================
module fifo_wr_arbiter #(
    parameter int N_REQ  = 3,
    parameter int DW     = 3,
    parameter int SETTLE = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N_REQ-1:0]    req,
    input  logic [N_REQ*DW-1:0] din,
    input  logic                fifo_full,
    output logic                fifo_wr,
    output logic [DW-1:0]       fifo_din,
    output logic [N_REQ-1:0]    grant,
    output logic [N_REQ-1:0]    ack,
    output logic [7:0]          drop_cnt
);

    localparam int IW = $clog2(N_REQ);

    localparam logic [1:0] c_ST_IDLE   = 2'd0;
    localparam logic [1:0] c_ST_LOAD   = 2'd1;
    localparam logic [1:0] c_ST_PULSE  = 2'd2;
    localparam logic [1:0] c_ST_SETTLE = 2'd3;

    localparam logic [IW-1:0] c_LAST_RST    = IW'(N_REQ - 1);
    localparam logic [3:0]    c_SETTLE_LAST = 4'(SETTLE - 1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [N_REQ-1:0] sync1_q, sync1_d;
    logic [N_REQ-1:0] sync2_q, sync2_d;
    logic [N_REQ-1:0] prev_q,  prev_d;
    logic [1:0]       warm_q,  warm_d;
    logic [N_REQ-1:0] pend_q,  pend_d;
    logic [7:0]       drop_cnt_q, drop_cnt_d;
    logic [1:0]       state_q, state_d;
    logic [IW-1:0]    win_q,   win_d;
    logic [IW-1:0]    last_q,  last_d;
    logic [3:0]       cnt_q,   cnt_d;
    logic [N_REQ-1:0] grant_q, grant_d;
    logic [N_REQ-1:0] ack_q,   ack_d;
    logic             fifo_wr_q, fifo_wr_d;
    logic [DW-1:0]    fifo_din_q, fifo_din_d;

    // ------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------
    logic [N_REQ-1:0] w_rise;
    logic [N_REQ-1:0] w_clr;
    logic [N_REQ-1:0] w_drop;
    logic [3:0]       w_ndrop;
    logic [8:0]       w_drop_sum;
    logic             w_any;
    logic             w_found;
    logic [IW-1:0]    w_pick;
    logic [IW-1:0]    w_cand;
    int               w_idx;
    logic             w_start;

    function automatic logic [N_REQ-1:0] onehot(input logic [IW-1:0] i);
        logic [N_REQ-1:0] v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    // ------------------------------------------------------------------
    // Synchronizers, edge detection, pending bits and drop counter
    // ------------------------------------------------------------------
    always_comb begin
        sync1_d = req;
        sync2_d = sync1_q;
        prev_d  = sync2_q;

        // Edges are ignored until the synchronizer chain and the previous-
        // level register all hold real samples, so a request that was already
        // high when reset released does not look like a fresh press.
        warm_d = (warm_q == 2'd3) ? 2'd3 : warm_q + 2'd1;
        w_rise = (warm_q == 2'd3) ? (sync2_q & ~prev_q) : '0;

        w_clr  = (state_q == c_ST_PULSE) ? onehot(win_q) : '0;

        // An edge landing in the PULSE cycle of its own requester is a new
        // request, not an overlap, so it is neither dropped nor cleared.
        w_drop = w_rise & pend_q & ~w_clr;
        pend_d = (pend_q & ~w_clr) | w_rise;

        w_ndrop = 4'd0;
        for (int i = 0; i < N_REQ; i++) begin
            w_ndrop = w_ndrop + {3'd0, w_drop[i]};
        end
        w_drop_sum = {1'b0, drop_cnt_q} + {5'd0, w_ndrop};
        drop_cnt_d = w_drop_sum[8] ? 8'hFF : w_drop_sum[7:0];
    end

    // ------------------------------------------------------------------
    // Round-robin pick: first pending index after last, wrapping
    // ------------------------------------------------------------------
    always_comb begin
        w_any   = |pend_q;
        w_found = 1'b0;
        w_pick  = last_q;
        w_idx   = 0;
        w_cand  = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            w_idx = int'(last_q) + k;
            if (w_idx >= N_REQ) begin
                w_idx = w_idx - N_REQ;
            end
            w_cand = IW'(w_idx);
            if (!w_found && pend_q[w_cand]) begin
                w_found = 1'b1;
                w_pick  = w_cand;
            end
        end
    end

    // ------------------------------------------------------------------
    // Transaction FSM
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        win_d      = win_q;
        last_d     = last_q;
        cnt_d      = cnt_q;
        grant_d    = grant_q;
        fifo_din_d = fifo_din_q;
        fifo_wr_d  = 1'b0;
        ack_d      = '0;
        w_start    = 1'b0;

        case (state_q)
            c_ST_IDLE: begin
                grant_d = '0;
                if (w_any) begin
                    w_start = 1'b1;
                end
            end
            c_ST_LOAD: begin
                if (!fifo_full) begin
                    state_d   = c_ST_PULSE;
                    fifo_wr_d = 1'b1;
                    ack_d     = grant_q;
                end
            end
            c_ST_PULSE: begin
                last_d  = win_q;
                cnt_d   = c_SETTLE_LAST;
                state_d = c_ST_SETTLE;
            end
            c_ST_SETTLE: begin
                if (cnt_q == 4'd0) begin
                    // The final SETTLE cycle performs the IDLE arbitration
                    // itself, so back-to-back writes are spaced by exactly
                    // LOAD + PULSE + SETTLE cycles.
                    if (w_any) begin
                        w_start = 1'b1;
                    end else begin
                        state_d = c_ST_IDLE;
                        grant_d = '0;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: begin
                state_d = c_ST_IDLE;
                grant_d = '0;
            end
        endcase

        if (w_start) begin
            state_d    = c_ST_LOAD;
            win_d      = w_pick;
            grant_d    = onehot(w_pick);
            fifo_din_d = din[int'(w_pick)*DW +: DW];
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            prev_q     <= '0;
            warm_q     <= 2'd0;
            pend_q     <= '0;
            drop_cnt_q <= 8'd0;
            state_q    <= c_ST_IDLE;
            win_q      <= '0;
            last_q     <= c_LAST_RST;
            cnt_q      <= 4'd0;
            grant_q    <= '0;
            ack_q      <= '0;
            fifo_wr_q  <= 1'b0;
            fifo_din_q <= '0;
        end else begin
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            prev_q     <= prev_d;
            warm_q     <= warm_d;
            pend_q     <= pend_d;
            drop_cnt_q <= drop_cnt_d;
            state_q    <= state_d;
            win_q      <= win_d;
            last_q     <= last_d;
            cnt_q      <= cnt_d;
            grant_q    <= grant_d;
            ack_q      <= ack_d;
            fifo_wr_q  <= fifo_wr_d;
            fifo_din_q <= fifo_din_d;
        end
    end

    assign fifo_wr  = fifo_wr_q;
    assign fifo_din = fifo_din_q;
    assign grant    = grant_q;
    assign ack      = ack_q;
    assign drop_cnt = drop_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fifo_wr_arbiter
//  Purpose  : Self-checking bench for fifo_wr_arbiter (N_REQ=3, DW=3,
//             SETTLE=3). A table of single-request transactions is replayed
//             in a loop, followed by directed multi-cycle sequences.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fifo_wr_arbiter;

    localparam int N  = 3;
    localparam int W  = 3;
    localparam int ST = 3;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [N-1:0] req = '0;
    logic [N*W-1:0] din = '0;
    logic         fifo_full = 1'b0;
    logic         fifo_wr;
    logic [W-1:0] fifo_din;
    logic [N-1:0] grant;
    logic [N-1:0] ack;
    logic [7:0]   drop_cnt;

    fifo_wr_arbiter #(.N_REQ(N), .DW(W), .SETTLE(ST)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .din       (din),
        .fifo_full (fifo_full),
        .fifo_wr   (fifo_wr),
        .fifo_din  (fifo_din),
        .grant     (grant),
        .ack       (ack),
        .drop_cnt  (drop_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int wr_cnt = 0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (fifo_wr === 1'b1) wr_cnt <= wr_cnt + 1;
    end

    typedef struct {
        int         idx;
        logic [2:0] dat;
        logic [2:0] exp_grant;
        logic [2:0] exp_dout;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        fifo_full = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic wait_grant(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (grant != '0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_wr(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (fifo_wr === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic run_vec(input vec_t v);
        bit ok;
        din = 9'($urandom);
        din[v.idx*W +: W] = v.dat;
        req[v.idx] = 1'b1;
        wait_grant(20, ok);
        chk("vec_grant_seen", 32'(ok), 32'd1);
        chk("vec_load_grant", 32'(grant), 32'(v.exp_grant));
        chk("vec_load_din",   32'(fifo_din), 32'(v.exp_dout));
        chk("vec_load_nowr",  32'(fifo_wr), 32'd0);
        req[v.idx] = 1'b0;
        din = 9'($urandom);
        @(negedge clk);
        chk("vec_pulse_wr",  32'(fifo_wr), 32'd1);
        chk("vec_pulse_ack", 32'(ack), 32'(v.exp_grant));
        chk("vec_pulse_din", 32'(fifo_din), 32'(v.exp_dout));
        for (int s = 0; s < ST; s++) begin
            din = 9'($urandom);
            @(negedge clk);
            chk("vec_settle_wr",    32'(fifo_wr), 32'd0);
            chk("vec_settle_ack",   32'(ack), 32'd0);
            chk("vec_settle_grant", 32'(grant), 32'(v.exp_grant));
            chk("vec_settle_din",   32'(fifo_din), 32'(v.exp_dout));
        end
        @(negedge clk);
        chk("vec_idle_grant", 32'(grant), 32'd0);
    endtask

    initial begin
        bit         ok;
        int         t_prev;
        int         w0;
        bit         saw_grant;
        logic [2:0] e;
        logic [2:0] a;

        vecs[0] = '{1, 3'd5, 3'b010, 3'd5};
        vecs[1] = '{0, 3'd3, 3'b001, 3'd3};
        vecs[2] = '{2, 3'd6, 3'b100, 3'd6};
        vecs[3] = '{1, 3'd2, 3'b010, 3'd2};
        vecs[4] = '{2, 3'd7, 3'b100, 3'd7};

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_wr",    32'(fifo_wr), 32'd0);
        chk("rst_din",   32'(fifo_din), 32'd0);
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_ack",   32'(ack), 32'd0);
        chk("rst_drop",  32'(drop_cnt), 32'd0);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        // Table-driven single transactions
        for (int i = 0; i < 5; i++) begin
            run_vec(vecs[i]);
        end
        chk("vec_drop", 32'(drop_cnt), 32'd0);

        // Three simultaneous requests: order 0,1,2 spaced 2+SETTLE
        do_reset();
        req = 3'b111;
        t_prev = 0;
        for (int t = 0; t < 3; t++) begin
            wait_wr(40, ok);
            chk("sim_wr_seen", 32'(ok), 32'd1);
            e = 3'b001 << t;
            chk("sim_order", 32'(ack), 32'(e));
            if (t > 0) chk("sim_gap", 32'(cyc - t_prev), 32'(ST + 2));
            t_prev = cyc;
            req = 3'b000;
        end
        repeat (ST + 2) @(negedge clk);
        chk("sim_drop", 32'(drop_cnt), 32'd0);
        chk("sim_idle", 32'(grant), 32'd0);

        // Full backpressure
        do_reset();
        fifo_full = 1'b1;
        req[2] = 1'b1;
        wait_grant(20, ok);
        chk("bp_grant_seen", 32'(ok), 32'd1);
        req = 3'b000;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("bp_hold_grant", 32'(grant), 32'b100);
            chk("bp_hold_nowr",  32'(fifo_wr), 32'd0);
        end
        fifo_full = 1'b0;
        @(negedge clk);
        chk("bp_wr_after", 32'(fifo_wr), 32'd1);
        chk("bp_ack",      32'(ack), 32'b100);
        repeat (ST + 1) @(negedge clk);
        chk("bp_idle", 32'(grant), 32'd0);

        // Overflow: four presses while the first is stuck on a full FIFO
        do_reset();
        fifo_full = 1'b1;
        for (int p = 0; p < 4; p++) begin
            req[0] = 1'b1;
            repeat (2) @(negedge clk);
            req[0] = 1'b0;
            repeat (3) @(negedge clk);
        end
        repeat (4) @(negedge clk);
        chk("ovf_drop", 32'(drop_cnt), 32'd3);
        w0 = wr_cnt;
        fifo_full = 1'b0;
        repeat (30) @(negedge clk);
        chk("ovf_one_write", 32'(wr_cnt - w0), 32'd1);
        chk("ovf_drop_after", 32'(drop_cnt), 32'd3);

        // Reset mid-SETTLE, with req[0] held high across the reset
        do_reset();
        din = 9'b000_111_000;
        req[1] = 1'b1;
        wait_wr(20, ok);
        chk("mid_wr_seen", 32'(ok), 32'd1);
        req[1] = 1'b0;
        @(negedge clk);
        chk("mid_settle_grant", 32'(grant), 32'b010);
        req[0] = 1'b1;
        #1 rst = 1'b1;
        #1;
        chk("mid_rst_wr",    32'(fifo_wr), 32'd0);
        chk("mid_rst_grant", 32'(grant), 32'd0);
        chk("mid_rst_ack",   32'(ack), 32'd0);
        chk("mid_rst_din",   32'(fifo_din), 32'd0);
        chk("mid_rst_drop",  32'(drop_cnt), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        w0 = wr_cnt;
        saw_grant = 1'b0;
        repeat (25) begin
            @(negedge clk);
            if (grant != '0) saw_grant = 1'b1;
        end
        chk("mid_no_wr",    32'(wr_cnt - w0), 32'd0);
        chk("mid_no_grant", 32'(saw_grant), 32'd0);
        req = 3'b000;

        // Fairness: req0/req1 re-pressed after every write
        do_reset();
        req = 3'b011;
        for (int k = 0; k < 8; k++) begin
            wait_wr(60, ok);
            chk("fair_wr_seen", 32'(ok), 32'd1);
            e = (k % 2 == 0) ? 3'b001 : 3'b010;
            chk("fair_order", 32'(ack), 32'(e));
            a = ack;
            req = req & ~a;
            @(negedge clk);
            req = req | a;
        end
        req = 3'b000;
        repeat (2 * (ST + 2) + 8) @(negedge clk);
        chk("fair_drop", 32'(drop_cnt), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
        $fatal(1);
    end

endmodule
`default_nettype wire
